// File: rtl/mux4_rr_arbiter.sv
// Round-robin scheduler for a shared 4:1 mux: registered selects, one-hot grant,
// and a hold-time quantum that preempts an owner while other sources are waiting.
module mux4_rr_arbiter #(
  parameter int unsigned QUANTUM = 4,
  parameter int unsigned CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  output logic          S1,
  output logic          S0,
  output logic [3:0]    gnt,
  output logic          valid,
  output logic [CW-1:0] hold_cnt
);

  // state    | meaning
  // ST_IDLE  | no owner; gnt=0, valid=0, selects hold their last value
  // ST_GRANT | owner drives the mux; hold_cnt counts its consecutive cycles
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CW-1:0] QUANT   = CW'(QUANTUM);
  localparam logic [CW-1:0] HOLD_1  = CW'(1);

  logic [0:0]    state;
  logic [1:0]    owner;
  logic [1:0]    last;

  logic [0:0]    nxt_state;
  logic [1:0]    nxt_owner;
  logic [1:0]    nxt_last;
  logic [CW-1:0] nxt_hold;

  logic [1:0]    ref_idx;
  logic [3:0]    owner_oh;
  logic [3:0]    cand;
  logic [1:0]    probe;
  logic          win_found;
  logic [1:0]    win_idx;

  assign owner_oh = 4'b0001 << owner;
  assign ref_idx  = (state == ST_GRANT) ? owner : last;
  // The current owner never competes against itself for the next slot.
  assign cand     = (state == ST_GRANT) ? (req & ~owner_oh) : req;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ref_idx;
    probe     = ref_idx;
    for (int i = 1; i <= 4; i++) begin
      probe = ref_idx + 2'(i);
      if (!win_found && cand[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_last  = last;
    nxt_hold  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          nxt_state = ST_GRANT;
          nxt_owner = win_idx;
          nxt_hold  = HOLD_1;
        end
      end
      ST_GRANT: begin
        if (!req[owner]) begin
          nxt_last = owner;
          if (win_found) begin
            nxt_owner = win_idx;
            nxt_hold  = HOLD_1;
          end else begin
            nxt_state = ST_IDLE;
            nxt_hold  = '0;
          end
        end else if (hold_cnt < QUANT) begin
          nxt_hold = hold_cnt + HOLD_1;
        end else if (win_found) begin
          nxt_last  = owner;
          nxt_owner = win_idx;
          nxt_hold  = HOLD_1;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_hold  = '0;
      end
    endcase
  end

  // Outputs are computed from next-state values so they are pure flops (glitch-free selects).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= 2'd0;
      last     <= 2'd3;
      hold_cnt <= '0;
      gnt      <= 4'b0000;
      valid    <= 1'b0;
      S1       <= 1'b0;
      S0       <= 1'b0;
    end else begin
      state    <= nxt_state;
      owner    <= nxt_owner;
      last     <= nxt_last;
      hold_cnt <= nxt_hold;
      if (nxt_state == ST_GRANT) begin
        gnt   <= 4'b0001 << nxt_owner;
        valid <= 1'b1;
        S1    <= nxt_owner[1];
        S0    <= nxt_owner[0];
      end else begin
        gnt   <= 4'b0000;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a QUANTUM=4 instance and a QUANTUM=1 instance.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] req1;

  logic       s1_a, s0_a, valid_a;
  logic [3:0] gnt_a;
  logic [7:0] hold_a;
  logic       s1_b, s0_b, valid_b;
  logic [3:0] gnt_b;
  logic [7:0] hold_b;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.QUANTUM(4), .CW(8)) u_q4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .S1(s1_a), .S0(s0_a), .gnt(gnt_a), .valid(valid_a), .hold_cnt(hold_a)
  );

  mux4_rr_arbiter #(.QUANTUM(1), .CW(8)) u_q1 (
    .clk(clk), .rst_n(rst_n), .req(req1),
    .S1(s1_b), .S0(s0_b), .gnt(gnt_b), .valid(valid_b), .hold_cnt(hold_b)
  );

  typedef struct {
    int         dut;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] hold;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input int dut, input logic [3:0] eg,
                               input logic [1:0] es, input logic ev, input logic [7:0] eh);
    if (dut == 0) begin
      check({tag, ".gnt"},   32'(gnt_a),        32'(eg));
      check({tag, ".sel"},   32'({s1_a, s0_a}), 32'(es));
      check({tag, ".valid"}, 32'(valid_a),      32'(ev));
      check({tag, ".hold"},  32'(hold_a),       32'(eh));
    end else begin
      check({tag, ".gnt"},   32'(gnt_b),        32'(eg));
      check({tag, ".sel"},   32'({s1_b, s0_b}), 32'(es));
      check({tag, ".valid"}, 32'(valid_b),      32'(ev));
      check({tag, ".hold"},  32'(hold_b),       32'(eh));
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      check_outputs(mon_e.tag, mon_e.dut, mon_e.gnt, mon_e.sel, mon_e.valid, mon_e.hold);
    end
  end

  // Called between a negedge and the following posedge: drives req for the next edge,
  // queues the outputs expected after that edge, and returns once the monitor has checked.
  task automatic step(input string tag, input int dut, input logic [3:0] r,
                      input logic [3:0] eg, input logic [1:0] es, input logic ev,
                      input logic [7:0] eh);
    exp_t e;
    if (dut == 0) req = r; else req1 = r;
    e.dut = dut; e.gnt = eg; e.sel = es; e.valid = ev; e.hold = eh; e.tag = tag;
    sbq.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Asynchronous reset pulse with no clock edge in between; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_outputs({tag, "_a"}, 0, 4'b0000, 2'b00, 1'b0, 8'd0);
    check_outputs({tag, "_b"}, 1, 4'b0000, 2'b00, 1'b0, 8'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    req1  = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    pulse_reset("rst0");

    // Single request, then release: selects hold while idle.
    step("t1_grant", 0, 4'b0001, 4'b0001, 2'b00, 1'b1, 8'd1);
    step("t1_drop",  0, 4'b0000, 4'b0000, 2'b00, 1'b0, 8'd0);
    step("t1_idle",  0, 4'b0000, 4'b0000, 2'b00, 1'b0, 8'd0);

    // Full contention with QUANTUM=4: four cycles per owner, rotating 0..3 then 0.
    req = 4'b0000;
    pulse_reset("rst2");
    for (int o = 0; o < 4; o++) begin
      for (int h = 1; h <= 4; h++) begin
        step("t2_rr", 0, 4'b1111, 4'(4'b0001 << o), 2'(o), 1'b1, 8'(h));
      end
    end
    step("t2_wrap", 0, 4'b1111, 4'b0001, 2'b00, 1'b1, 8'd1);

    // Lone holder is never preempted and the counter saturates.
    req = 4'b0000;
    pulse_reset("rst3");
    for (int h = 1; h <= 10; h++) begin
      step("t3_sat", 0, 4'b0100, 4'b0100, 2'b10, 1'b1, (h > 4) ? 8'd4 : 8'(h));
    end

    // Owner b releases while a and d wait: search starts at c, d wins, no bubble.
    req = 4'b0000;
    pulse_reset("rst4");
    step("t4_b",    0, 4'b0010, 4'b0010, 2'b01, 1'b1, 8'd1);
    step("t4_hand", 0, 4'b1001, 4'b1000, 2'b11, 1'b1, 8'd1);
    step("t4_hold", 0, 4'b1001, 4'b1000, 2'b11, 1'b1, 8'd2);

    // Reset mid-grant with owner c, then re-grant one edge after release.
    req = 4'b0000;
    pulse_reset("rst5a");
    step("t5_c", 0, 4'b0100, 4'b0100, 2'b10, 1'b1, 8'd1);
    pulse_reset("rst5_mid");
    step("t5_regrant", 0, 4'b0100, 4'b0100, 2'b10, 1'b1, 8'd1);

    // QUANTUM=1 instance: grant alternates a/b every cycle.
    req = 4'b0000;
    pulse_reset("rst6");
    for (int k = 0; k < 6; k++) begin
      step("t6_q1", 1, 4'b0011, (k % 2 == 0) ? 4'b0001 : 4'b0010,
           (k % 2 == 0) ? 2'b00 : 2'b01, 1'b1, 8'd1);
    end

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
